natural_exp: RTL and testbench

Sequential fixed-point exponential unit that computes e^x for a signed Q4.8 operand and returns an unsigned Q16.8 result. It is the inverse of the natural-log block. Discrete-circuit models use it to turn log-domain quantities back into linear voltages and currents, for example RC charge/discharge terms e^(-t/RC) and diode/transistor exponential laws. It uses a single shared multiplier over a short FSM, so many instances can sit in an audio-rate pipeline cheaply.

---
 rtl/natural_exp_if.sv | 25 ++
 rtl/natural_exp.sv | 112 +++++++++++
 tb/tb_natural_exp.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/natural_exp_if.sv
// Request/result bundle for the natural_exp unit: the requester drives start and the
// Q4.8 operand, and the unit returns busy, a done strobe and the Q16.8 result.
interface natural_exp_if;
   logic               start;
   logic signed [11:0] in_8_shifted;
   logic               busy;
   logic               done;
   logic        [23:0] out_8_shifted;

   modport master (
      output start,
      output in_8_shifted,
      input  busy,
      input  done,
      input  out_8_shifted
   );

   modport slave (
      input  start,
      input  in_8_shifted,
      output busy,
      output done,
      output out_8_shifted
   );
endinterface

// File: rtl/natural_exp.sv
// Sequential e^x for a signed Q4.8 operand, producing an unsigned Q16.8 result.
// e^x = 2^k * 2^f, with 2^f from a cubic Horner evaluation on one shared multiplier.
module natural_exp #(
   parameter int unsigned LOG2E_16_SHIFTED = 94548,
   parameter int unsigned C1_16_SHIFTED    = 45600,
   parameter int unsigned C2_16_SHIFTED    = 14752,
   parameter int unsigned C3_16_SHIFTED    = 5184
) (
   input logic          clk,
   input logic          I_RST,
   natural_exp_if.slave bus
);

   typedef enum logic [2:0] {StIdle, StMul, StH1, StH2, StH3, StOut} state_e;

   state_e             state_q, state_d;
   logic signed [11:0] x_q, x_d;
   logic        [4:0]  kb_q, kb_d;   // k + 12, so the range -12..11 maps onto 0..23
   logic        [15:0] f_q, f_d;
   logic        [17:0] acc_q, acc_d;
   logic        [23:0] out_q, out_d;
   logic               done_q, done_d;

   logic signed [17:0] mul_a, mul_b;
   logic signed [35:0] prod;
   logic        [17:0] step;
   logic        [23:0] m_ext;
   logic               unused_prod;

   assign prod        = mul_a * mul_b;
   assign step        = prod[33:16];
   assign m_ext       = {6'd0, acc_q};
   assign unused_prod = ^{prod[35:34], prod[7:0]};

   always_ff @(posedge clk) begin
      if (I_RST) begin
         state_q <= StIdle;
         x_q     <= '0;
         kb_q    <= '0;
         f_q     <= '0;
         acc_q   <= '0;
         out_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         kb_q    <= kb_d;
         f_q     <= f_d;
         acc_q   <= acc_d;
         out_q   <= out_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      kb_d    = kb_q;
      f_d     = f_q;
      acc_d   = acc_q;
      out_d   = out_q;
      done_d  = 1'b0;
      mul_a   = $signed(acc_q);
      mul_b   = $signed({2'b00, f_q});

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               x_d     = bus.in_8_shifted;
               state_d = StMul;
            end
         end
         StMul: begin
            // Range reduction: p = x * log2(e) in Q8.24; floor via arithmetic slice.
            mul_a   = {{6{x_q[11]}}, x_q};
            mul_b   = 18'(LOG2E_16_SHIFTED);
            kb_d    = prod[28:24] + 5'd12;
            f_d     = prod[23:8];
            acc_d   = 18'(C3_16_SHIFTED);
            state_d = StH1;
         end
         StH1: begin
            acc_d   = 18'(C2_16_SHIFTED) + step;
            state_d = StH2;
         end
         StH2: begin
            acc_d   = 18'(C1_16_SHIFTED) + step;
            state_d = StH3;
         end
         StH3: begin
            acc_d   = 18'd65536 + step;
            state_d = StOut;
         end
         StOut: begin
            // k >= 8 shifts left by k-8, otherwise right by 8-k (k <= -10 flushes to zero).
            if (kb_q >= 5'd20) begin
               out_d = m_ext << (kb_q - 5'd20);
            end else begin
               out_d = m_ext >> (5'd20 - kb_q);
            end
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign bus.busy          = (state_q != StIdle);
   assign bus.done          = done_q;
   assign bus.out_8_shifted = out_q;

endmodule

// File: tb/tb_natural_exp.sv
// Directed bench for natural_exp: reset, hand-computed vectors, handshake timing,
// restart/abort behaviour and a full operand sweep against a bit-exact model.
module tb_natural_exp;

   logic clk;
   logic I_RST;
   int   n_tests;
   int   n_fail;

   natural_exp_if nif ();

   natural_exp dut (
      .clk   (clk),
      .I_RST (I_RST),
      .bus   (nif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int model_exp(input int x);
      longint p, k, f, a, r;
      p = longint'(x) * 64'sd94548;
      k = p >>> 24;
      f = (p - k * 64'sd16777216) >>> 8;
      a = 64'sd5184;
      a = 64'sd14752 + ((a * f) >>> 16);
      a = 64'sd45600 + ((a * f) >>> 16);
      a = 64'sd65536 + ((a * f) >>> 16);
      if (k >= 8) r = a <<< (k - 8);
      else        r = a >>> (8 - k);
      return int'(r);
   endfunction

   // Issue one request and wait (bounded) for done; lat = -1 on timeout.
   task automatic run_conv(input int x, output logic [23:0] res, output int lat);
      @(negedge clk);
      nif.start        = 1'b1;
      nif.in_8_shifted = 12'(x);
      @(negedge clk);
      nif.start = 1'b0;
      lat = -1;
      res = '0;
      for (int i = 1; i <= 12; i++) begin
         if (i > 1) @(negedge clk);
         if (nif.done) begin
            lat = i - 1;
            res = nif.out_8_shifted;
            break;
         end
      end
   endtask

   task automatic test_reset();
      I_RST = 1'b1;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({nif.busy, nif.done, nif.out_8_shifted} !== 26'd0) begin
         n_fail++;
         $display("FAIL reset_state: busy=%0b done=%0b out=%0d, want 0/0/0",
                  nif.busy, nif.done, nif.out_8_shifted);
      end
      I_RST = 1'b0;
   endtask

   task automatic test_busy_window();
      logic [1:0] want;
      @(negedge clk);
      nif.start        = 1'b1;
      nif.in_8_shifted = 12'sd0;
      for (int i = 1; i <= 7; i++) begin
         @(negedge clk);
         nif.start = 1'b0;
         want = {(i <= 5), (i == 6)};
         n_tests++;
         if ({nif.busy, nif.done} !== want) begin
            n_fail++;
            $display("FAIL busy_window cycle %0d: busy,done=%b, want %b", i,
                     {nif.busy, nif.done}, want);
         end
         if (i == 6) begin
            n_tests++;
            if (nif.out_8_shifted !== 24'd256) begin
               n_fail++;
               $display("FAIL zero_result: out=%0d, want 256", nif.out_8_shifted);
            end
         end
      end
   endtask

   task automatic test_vectors();
      int          xs [7];
      int          ws [7];
      logic [23:0] res;
      int          lat;
      xs = '{256, 177, -256, -2048, 2047, -1792, 0};
      ws = '{695, 511, 94, 0, 760032, 0, 256};
      for (int v = 0; v < 7; v++) begin
         run_conv(xs[v], res, lat);
         n_tests++;
         if (lat != 5 || res !== 24'(ws[v])) begin
            n_fail++;
            $display("FAIL vector x=%0d: out=%0d lat=%0d, want %0d lat=5", xs[v], res, lat,
                     ws[v]);
         end
      end
   endtask

   task automatic test_ignore_restart();
      int ndone;
      int at;
      @(negedge clk);
      nif.start        = 1'b1;
      nif.in_8_shifted = 12'sd177;
      ndone = 0;
      at    = -1;
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk);
         if (i == 1) nif.in_8_shifted = -12'sd256;
         if (i == 4) nif.start = 1'b0;
         if (nif.done) begin
            ndone++;
            at = i;
            n_tests++;
            if (nif.out_8_shifted !== 24'd511) begin
               n_fail++;
               $display("FAIL ignore_restart_value: out=%0d, want 511", nif.out_8_shifted);
            end
         end
      end
      n_tests++;
      if (ndone != 1 || at != 6) begin
         n_fail++;
         $display("FAIL ignore_restart_count: dones=%0d at=%0d, want 1 at 6", ndone, at);
      end
   endtask

   task automatic test_back_to_back();
      int hits [$];
      @(negedge clk);
      nif.start        = 1'b1;
      nif.in_8_shifted = 12'sd256;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (nif.done) begin
            hits.push_back(i);
            n_tests++;
            if (nif.out_8_shifted !== 24'd695) begin
               n_fail++;
               $display("FAIL back_to_back_value: out=%0d, want 695", nif.out_8_shifted);
            end
         end
      end
      nif.start = 1'b0;
      repeat (10) @(negedge clk);
      n_tests++;
      if (hits.size() != 6 || hits[0] != 6) begin
         n_fail++;
         $display("FAIL back_to_back_count: dones=%0d first=%0d, want 6 first=6", hits.size(),
                  (hits.size() > 0) ? hits[0] : -1);
      end
      for (int j = 1; j < hits.size(); j++) begin
         n_tests++;
         if (hits[j] - hits[j-1] != 6) begin
            n_fail++;
            $display("FAIL back_to_back_period: gap=%0d, want 6", hits[j] - hits[j-1]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [23:0] res;
      int          lat;
      int          ndone;
      run_conv(256, res, lat);
      @(negedge clk);
      nif.start        = 1'b1;
      nif.in_8_shifted = 12'sd256;
      @(negedge clk);
      nif.start = 1'b0;
      repeat (2) @(negedge clk);
      I_RST = 1'b1;
      @(negedge clk);
      I_RST = 1'b0;
      n_tests++;
      if ({nif.busy, nif.done, nif.out_8_shifted} !== 26'd0) begin
         n_fail++;
         $display("FAIL reset_mid_state: busy=%0b done=%0b out=%0d, want 0/0/0",
                  nif.busy, nif.done, nif.out_8_shifted);
      end
      ndone = 0;
      repeat (10) begin
         @(negedge clk);
         if (nif.done) ndone++;
      end
      n_tests++;
      if (ndone != 0) begin
         n_fail++;
         $display("FAIL reset_mid_no_done: dones=%0d, want 0", ndone);
      end
      run_conv(-256, res, lat);
      n_tests++;
      if (lat != 5 || res !== 24'd94) begin
         n_fail++;
         $display("FAIL after_reset: out=%0d lat=%0d, want 94 lat=5", res, lat);
      end
   endtask

   task automatic test_sweep();
      logic [23:0] res;
      int          lat;
      int          want;
      real         r;
      real         diff;
      for (int i = 0; i < 4096; i++) begin
         run_conv(i - 2048, res, lat);
         want = model_exp(i - 2048);
         n_tests++;
         if (lat != 5 || res !== 24'(want)) begin
            n_fail++;
            $display("FAIL sweep_exact x=%0d: out=%0d lat=%0d, want %0d", i - 2048, res, lat,
                     want);
         end
         r    = $exp(real'(i - 2048) / 256.0) * 256.0;
         diff = real'(res) - r;
         if (diff < 0.0) diff = -diff;
         n_tests++;
         if (diff > 0.0005 * r + 1.0) begin
            n_fail++;
            $display("FAIL sweep_accuracy x=%0d: out=%0d, want %f within %f", i - 2048, res, r,
                     0.0005 * r + 1.0);
         end
      end
   endtask

   initial begin
      n_tests          = 0;
      n_fail           = 0;
      I_RST            = 1'b1;
      nif.start        = 1'b0;
      nif.in_8_shifted = '0;
      test_reset();
      test_busy_window();
      test_vectors();
      test_ignore_restart();
      test_back_to_back();
      test_reset_mid();
      test_sweep();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
